// File: rtl/alu_4_bit_arbiter.sv
// Two-port arbiter in front of a shared combinational ALU; optional rsp_zero via ALU_ARB_ZERO_FLAG_EN.
// Latency: request handshake -> rsp_valid two edges later (IDLE/EXEC/RESP, one op per 3 cycles).
// Backpressure: rsp_ready low parks the FSM in RESP; no request is accepted until the response drains.
module alu_4_bit_arbiter #(
    parameter int DATA_W = 4,
    parameter int OP_W   = 3,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id
`ifdef ALU_ARB_ZERO_FLAG_EN
    ,
    output logic              rsp_zero
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state, state_nxt;
    logic   rr_ptr;
    logic   grant0, grant1;
    logic   accept0, accept1;

    // rr_ptr only matters when both ports contend; a lone requester always wins
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if ((RR_EN != 0) && rr_ptr) grant1 = 1'b1;
            else                        grant0 = 1'b1;
        end else if (req0_valid) begin
            grant0 = 1'b1;
        end else if (req1_valid) begin
            grant1 = 1'b1;
        end
    end

    assign req0_ready = (state == IDLE) && grant0;
    assign req1_ready = (state == IDLE) && grant1;
    assign accept0    = req0_valid && req0_ready;
    assign accept1    = req1_valid && req1_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept0 || accept1) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
`ifdef ALU_ARB_ZERO_FLAG_EN
            rsp_zero  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept0) begin
                        alu_a  <= req0_a;
                        alu_b  <= req0_b;
                        alu_op <= req0_op;
                        rsp_id <= 1'b0;
                    end else if (accept1) begin
                        alu_a  <= req1_a;
                        alu_b  <= req1_b;
                        alu_op <= req1_op;
                        rsp_id <= 1'b1;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_result;
                    rsp_valid <= 1'b1;
`ifdef ALU_ARB_ZERO_FLAG_EN
                    rsp_zero  <= (alu_result == '0);
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (RR_EN != 0) rr_ptr <= ~rsp_id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_4_bit_arbiter.sv
// Directed bench for alu_4_bit_arbiter with a behavioural ALU on the alu_* bus.
module tb_alu_4_bit_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0] req0_op = '0, req1_op = '0;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_op;
    logic       rsp_valid, rsp_id;
    logic       rsp_ready = 1'b1;
    logic [3:0] rsp_data;
`ifdef ALU_ARB_ZERO_FLAG_EN
    logic       rsp_zero;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_4_bit_arbiter #(.DATA_W(4), .OP_W(3), .RR_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id)
`ifdef ALU_ARB_ZERO_FLAG_EN
        , .rsp_zero(rsp_zero)
`endif
    );

    always_comb begin
        case (alu_op)
            3'b001:  alu_result = alu_a + alu_b;
            3'b010:  alu_result = alu_a - alu_b;
            3'b011:  alu_result = alu_a & alu_b;
            3'b100:  alu_result = alu_a | alu_b;
            3'b101:  alu_result = alu_a ^ alu_b;
            3'b110:  alu_result = ~alu_a;
            3'b111:  alu_result = alu_a;
            default: alu_result = 4'h0;
        endcase
    end

    typedef struct {
        int         port;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] exp;
        logic       zero;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input int port, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        if (port == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    // Called just after a posedge with the FSM in IDLE; leaves the bench just after the accept edge.
    task automatic expect_grant(input int port);
        @(negedge clk);
        check("grant", {30'd0, req1_ready, req0_ready}, (port == 0) ? 32'd1 : 32'd2);
        @(posedge clk);
        #1;
        if (port == 0) req0_valid = 1'b0;
        else           req1_valid = 1'b0;
    endtask

    // Expects rsp_valid on the second negedge after the accept edge; returns just after the next posedge.
    task automatic wait_rsp(input logic [3:0] exp_data, input logic exp_id, input logic exp_zero);
        int cyc = 9;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                cyc = i;
                break;
            end
        end
        check("rsp_latency", cyc, 2);
        check("rsp_data", rsp_data, exp_data);
        check("rsp_id", rsp_id, exp_id);
`ifdef ALU_ARB_ZERO_FLAG_EN
        check("rsp_zero", rsp_zero, exp_zero);
`else
        if (exp_zero === 1'bx) $display("unexpected zero flag request");
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{0, 4'h3, 4'h5, 3'b001, 4'h8, 1'b0};
        vecs[1] = '{1, 4'hF, 4'h1, 3'b001, 4'h0, 1'b1};
        vecs[2] = '{0, 4'h0, 4'h1, 3'b010, 4'hF, 1'b0};
        vecs[3] = '{1, 4'hC, 4'hA, 3'b011, 4'h8, 1'b0};
        vecs[4] = '{0, 4'h1, 4'h2, 3'b100, 4'h3, 1'b0};
        vecs[5] = '{1, 4'h6, 4'h3, 3'b101, 4'h5, 1'b0};
        vecs[6] = '{0, 4'h9, 4'h0, 3'b110, 4'h6, 1'b0};
        vecs[7] = '{1, 4'h7, 4'h7, 3'b010, 4'h0, 1'b1};

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_alu_bus", {alu_a, alu_b, alu_op}, 0);
        check("rst_ready", {req1_ready, req0_ready}, 0);
        do_reset();

        // Single requests, including wrap-around in both directions
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].op);
            expect_grant(vecs[i].port);
            wait_rsp(vecs[i].exp, vecs[i].port[0], vecs[i].zero);
            check("alu_hold", {alu_a, alu_b, alu_op}, {vecs[i].a, vecs[i].b, vecs[i].op});
        end

        // Round-robin with both ports contending, twice
        do_reset();
        for (int r = 0; r < 2; r++) begin
            drive(0, 4'hC, 4'hA, 3'b011);
            drive(1, 4'h1, 4'h2, 3'b100);
            expect_grant(0);
            wait_rsp(4'h8, 1'b0, 1'b0);
            expect_grant(1);
            wait_rsp(4'h3, 1'b1, 1'b0);
        end

        // Back-pressure: response held, port 1 waits
        do_reset();
        drive(0, 4'h2, 4'h2, 3'b001);
        expect_grant(0);
        rsp_ready = 1'b0;
        drive(1, 4'h2, 4'h3, 3'b001);
        wait_rsp(4'h4, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {rsp_valid, rsp_id, req1_ready, rsp_data}, {1'b1, 1'b0, 1'b0, 4'h4});
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        expect_grant(1);
        wait_rsp(4'h5, 1'b1, 1'b0);

        // Reset during EXEC: nothing comes out, pointer back to port 0
        do_reset();
        drive(0, 4'h1, 4'h1, 3'b001);
        expect_grant(0);
        wait_rsp(4'h2, 1'b0, 1'b0);
        drive(1, 4'h2, 4'h3, 3'b001);
        expect_grant(1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_alu_op", alu_op, 0);
        check("midrst_alu_a", alu_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (rsp_valid) seen = 1'b1;
            end
            check("midrst_no_rsp", seen, 0);
        end
        @(posedge clk);
        #1;
        drive(0, 4'h4, 4'h4, 3'b001);
        drive(1, 4'h1, 4'h1, 3'b001);
        expect_grant(0);
        wait_rsp(4'h8, 1'b0, 1'b0);
        expect_grant(1);
        wait_rsp(4'h2, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
